// File: rtl/float_add_arbiter.sv
// Round-robin arbiter sharing one non-pipelined float adder between num_clients requesters.
// Operands are registered at grant; the result is returned only to the granted client.

module float_add_arbiter_lane (
  input  logic req,
  input  logic ack,
  output logic elig
);
  // A client acked this cycle is masked so its held request is not re-issued at once.
  assign elig = req & ~ack;
endmodule

module float_add_arbiter #(
  parameter  int num_clients = 4,
  parameter  int float_width = 32,
  localparam int id_w        = $clog2(num_clients)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [num_clients-1:0]             cli_req,
  input  logic [num_clients*float_width-1:0] cli_a,
  input  logic [num_clients*float_width-1:0] cli_b,
  output logic [num_clients-1:0]             cli_ack,
  output logic [float_width-1:0]             cli_out,
  output logic                               add_req,
  output logic [float_width-1:0]             add_a,
  output logic [float_width-1:0]             add_b,
  input  logic [float_width-1:0]             add_out,
  input  logic                               add_ack,
  output logic                               busy,
  output logic [id_w-1:0]                    grant_id
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [id_w-1:0]        rr_ptr;
  logic [id_w-1:0]        winner;
  logic [id_w-1:0]        rr_next;
  logic                   any_elig;
  logic [num_clients-1:0] elig;

  for (genvar i = 0; i < num_clients; i++) begin : g_lane
    float_add_arbiter_lane u_lane (
      .req  (cli_req[i]),
      .ack  (cli_ack[i]),
      .elig (elig[i])
    );
  end

  // First eligible index scanning upward from rr_ptr, wrapping.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    for (int k = 0; k < num_clients; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= num_clients) idx = idx - num_clients;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        winner   = id_w'(idx);
      end
    end
  end

  assign rr_next = (grant_id == id_w'(num_clients - 1)) ? '0 : grant_id + id_w'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_elig) state_d = WAIT;
      WAIT:    if (add_ack)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cli_ack  <= '0;
      cli_out  <= '0;
      add_req  <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      add_req <= 1'b0;
      cli_ack <= '0;
      case (state_q)
        IDLE: if (any_elig) begin
          add_a    <= cli_a[int'(winner)*float_width +: float_width];
          add_b    <= cli_b[int'(winner)*float_width +: float_width];
          add_req  <= 1'b1;
          grant_id <= winner;
          busy     <= 1'b1;
        end
        WAIT: if (add_ack) begin
          cli_out           <= add_out;
          cli_ack[grant_id] <= 1'b1;
          busy              <= 1'b0;
          rr_ptr            <= rr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_arbiter.sv
// Directed bench for float_add_arbiter with a 3-cycle stand-in adder answering known operand pairs.

module tb_float_add_arbiter;
  localparam int NC = 4;
  localparam int FW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NC-1:0]    cli_req = '0;
  logic [NC*FW-1:0] cli_a = '0;
  logic [NC*FW-1:0] cli_b = '0;
  logic [NC-1:0]    cli_ack;
  logic [FW-1:0]    cli_out;
  logic             add_req;
  logic [FW-1:0]    add_a, add_b;
  logic [FW-1:0]    add_out = '0;
  logic             add_ack = 1'b0;
  logic             busy;
  logic [1:0]       grant_id;

  int checks = 0, failures = 0;
  int viol = 0, ack_count = 0, areq_count = 0;
  bit stray = 1'b0;

  float_add_arbiter #(.num_clients(NC), .float_width(FW)) dut (
    .clk(clk), .rst(rst), .cli_req(cli_req), .cli_a(cli_a), .cli_b(cli_b),
    .cli_ack(cli_ack), .cli_out(cli_out), .add_req(add_req), .add_a(add_a),
    .add_b(add_b), .add_out(add_out), .add_ack(add_ack), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Hand-computed IEEE-754 single sums for the operand pairs used below.
  function automatic logic [31:0] sum_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3FC00000, 32'hBFC00000}: return 32'h00000000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h40800000, 32'h40800000}: return 32'h41000000;
      default:                      return 32'hFFFFFFFF;
    endcase
  endfunction

  int          cnt = 0;
  logic [31:0] ma = '0, mb = '0;
  always @(negedge clk) begin
    add_ack = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin add_ack = 1'b1; add_out = sum_lut(ma, mb); end
    end
    if (add_req) begin cnt = 3; ma = add_a; mb = add_b; end
    if (stray) begin add_ack = 1'b1; add_out = 32'h12345678; end
  end

  bit prev_req = 0, prev_busy = 0, prev_ack = 0;
  always @(negedge clk) begin
    if (add_req && (prev_req || prev_busy)) viol++;
    if ($countones(cli_ack) > 1 || (cli_ack != 0 && prev_ack)) viol++;
    if (cli_ack != 0) ack_count++;
    if (add_req) areq_count++;
    prev_req  = add_req;
    prev_busy = busy;
    prev_ack  = (cli_ack != 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b0; cli_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_op(input int c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit chg, input string tag);
    int k, busy_n, r0;
    r0 = areq_count;
    cli_a[c*FW +: FW] = a;
    cli_b[c*FW +: FW] = b;
    cli_req[c] = 1'b1;
    k = 0; busy_n = 0;
    do begin
      @(negedge clk);
      k++;
      if (busy) busy_n++;
      if (k == 1) begin
        chk({tag, "_add_req"}, add_req, 1);
        chk({tag, "_grant"}, grant_id, c);
        chk({tag, "_add_a"}, add_a, a);
      end
      if (chg && k == 2) begin
        cli_a[c*FW +: FW] = 32'h40800000;
        cli_b[c*FW +: FW] = 32'h40800000;
      end
      if (chg && k == 4) chk({tag, "_add_b_held"}, add_b, b);
    end while (cli_ack == 0 && k < 12);
    cli_req[c] = 1'b0;
    chk({tag, "_latency"}, k, 5);
    chk({tag, "_ack"}, cli_ack, 64'(1) << c);
    chk({tag, "_out"}, cli_out, exp);
    chk({tag, "_busy_cycles"}, busy_n, 4);
    chk({tag, "_add_req_pulses"}, areq_count - r0, 1);
  endtask

  initial begin
    int a0, n, idx;
    int order [4];
    logic [31:0] ea [4];
    logic [31:0] eb [4];
    logic [31:0] es [4];

    #1;
    chk("rst_ctl", {cli_ack, add_req, busy, grant_id}, 0);
    chk("rst_cli_out", cli_out, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 0, "single");
    run_op(2, 32'h3FC00000, 32'hBFC00000, 32'h00000000, 0, "cancel");
    run_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1, "stable");

    // Abort mid-operation
    cli_a[1*FW +: FW] = 32'h40000000;
    cli_b[1*FW +: FW] = 32'h40000000;
    cli_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_ctl", {cli_ack, add_req, busy, grant_id}, 0);
    chk("abort_cli_out", cli_out, 0);
    chk("abort_add_a", add_a, 0);
    chk("abort_add_b", add_b, 0);
    cli_req = '0;
    @(negedge clk); rst = 1'b1;
    a0 = ack_count;
    repeat (8) @(negedge clk);
    chk("abort_no_ack", ack_count - a0, 0);

    // Stray adder ack while idle
    a0 = ack_count;
    stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_no_ack", ack_count - a0, 0);
    chk("stray_busy", busy, 0);
    run_op(1, 32'h40000000, 32'h40000000, 32'h40800000, 0, "recover");

    // Contention: all four at once
    apply_reset();
    ea = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40800000};
    eb = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000};
    es = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h41000000};
    for (int i = 0; i < 4; i++) begin
      cli_a[i*FW +: FW] = ea[i];
      cli_b[i*FW +: FW] = eb[i];
      order[i] = -1;
    end
    cli_req = 4'b1111;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk);
      if (cli_ack != 0) begin
        idx = $clog2(cli_ack);
        order[n] = idx;
        chk("cont_out", cli_out, es[idx]);
        cli_req[idx] = 1'b0;
        n++;
      end
    end
    cli_req = '0;
    chk("cont_count", n, 4);
    for (int i = 0; i < 4; i++) chk("cont_order", order[i], i);

    // Fairness: clients 1 and 3 hold requests
    apply_reset();
    cli_a[1*FW +: FW] = 32'h3F800000; cli_b[1*FW +: FW] = 32'h3F800000;
    cli_a[3*FW +: FW] = 32'h40000000; cli_b[3*FW +: FW] = 32'h40000000;
    for (int i = 0; i < 4; i++) order[i] = -1;
    cli_req = 4'b1010;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk);
      if (cli_ack != 0) begin
        idx = $clog2(cli_ack);
        order[n] = idx;
        chk("fair_out", cli_out, (idx == 1) ? 32'h40000000 : 32'h40800000);
        n++;
      end
    end
    cli_req = '0;
    chk("fair_count", n, 4);
    chk("fair_0", order[0], 1);
    chk("fair_1", order[1], 3);
    chk("fair_2", order[2], 1);
    chk("fair_3", order[3], 3);

    repeat (8) @(negedge clk);
    chk("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
